// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl shared definitions.
// State codes are shared with the display mux and software.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    CRC_STOP = 2'd0,
    CRC_RUN  = 2'd1,
    CRC_STEP = 2'd2
  } crc_state_e;

endpackage

// File: rtl/cpu_run_ctrl_edge_det.sv
// edge_det: 1-bit rising-edge detector.
// A level held through reset yields an edge on the first cycle.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= level_i;
  end

  assign edge_o = level_i & ~prev_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/stop/step clock-enable generator for the core.
// Define CPU_RUN_BRK_EN to enable the address breakpoint halt.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_run,
  input  logic          btn_step,
  input  logic          btn_stop,
  input  logic [3:0]    rate_sel,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] brk_addr,
  input  logic          brk_en,
  output logic          cpu_en,
  output logic          running,
  output logic          brk_hit,
  output logic [31:0]   en_cnt,
  output logic [1:0]    state
);

  crc_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, term;
  logic [31:0]      en_cnt_q, en_cnt_d;
  logic             cpu_en_q, cpu_en_d;
  logic             brk_hit_q, brk_hit_d;
  logic             run_edge, step_edge, stop_edge;
  logic             brk_fire;

  edge_det u_run (
    .clk    (clk),
    .reset  (reset),
    .level_i(btn_run),
    .edge_o (run_edge)
  );

  edge_det u_step (
    .clk    (clk),
    .reset  (reset),
    .level_i(btn_step),
    .edge_o (step_edge)
  );

  edge_det u_stop (
    .clk    (clk),
    .reset  (reset),
    .level_i(btn_stop),
    .edge_o (stop_edge)
  );

  assign term = (DIV_W'(1) << rate_sel) - DIV_W'(1);

`ifdef CPU_RUN_BRK_EN
  assign brk_fire = (state_q == CRC_RUN) & cpu_en_q
                  & brk_en & (addr == brk_addr);
`else
  logic unused_brk;
  assign unused_brk = ^{addr, brk_addr, brk_en};
  assign brk_fire   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CRC_STOP;
      div_q     <= '0;
      en_cnt_q  <= '0;
      cpu_en_q  <= 1'b0;
      brk_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      en_cnt_q  <= en_cnt_d;
      cpu_en_q  <= cpu_en_d;
      brk_hit_q <= brk_hit_d;
    end
  end

  always_comb begin
    state_d = CRC_STOP;
    case (state_q)
      CRC_STOP: begin
        if (stop_edge)      state_d = CRC_STOP;
        else if (step_edge) state_d = CRC_STEP;
        else if (run_edge)  state_d = CRC_RUN;
      end
      CRC_RUN: begin
        if (stop_edge | brk_fire) state_d = CRC_STOP;
        else                      state_d = CRC_RUN;
      end
      default: state_d = CRC_STOP;
    endcase
  end

  // The divider is zero outside RUN, so the entry edge counts as tick one.
  always_comb begin
    div_d     = '0;
    cpu_en_d  = 1'b0;
    en_cnt_d  = en_cnt_q + {31'b0, cpu_en_q};
    brk_hit_d = 1'b0;
    if (state_d == CRC_STEP) begin
      cpu_en_d = 1'b1;
    end else if (state_d == CRC_RUN) begin
      if (div_q >= term) cpu_en_d = 1'b1;
      else               div_d    = div_q + DIV_W'(1);
    end
`ifdef CPU_RUN_BRK_EN
    brk_hit_d = brk_hit_q;
    if (brk_fire)
      brk_hit_d = 1'b1;
    else if (state_q == CRC_STOP && state_d != CRC_STOP)
      brk_hit_d = 1'b0;
`endif
  end

  assign cpu_en  = cpu_en_q;
  assign running = (state_q == CRC_RUN);
  assign brk_hit = brk_hit_q;
  assign en_cnt  = en_cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized and directed bench for cpu_run_ctrl.
// A behavioural model predicts every output each cycle.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_run = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_stop = 1'b0;
  logic [3:0]  rate_sel = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] brk_addr = 32'd0;
  logic        brk_en = 1'b0;
  logic        cpu_en, running, brk_hit;
  logic [31:0] en_cnt;
  logic [1:0]  state;

  int vectors = 0;
  int errors = 0;

`ifdef CPU_RUN_BRK_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DIV_W(16), .AW(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_run (btn_run),
    .btn_step(btn_step),
    .btn_stop(btn_stop),
    .rate_sel(rate_sel),
    .addr    (addr),
    .brk_addr(brk_addr),
    .brk_en  (brk_en),
    .cpu_en  (cpu_en),
    .running (running),
    .brk_hit (brk_hit),
    .en_cnt  (en_cnt),
    .state   (state)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=stopped 1=running 2=single step.
  int          m_mode;
  longint      m_since, m_period;
  bit          m_en, m_brk, m_was, m_hit, m_tick;
  bit          p_run, p_step, p_stop, e_run, e_step, e_stop;
  logic [31:0] m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_since = 0; m_en = 0; m_brk = 0; m_cnt = 0;
      p_run = 0; p_step = 0; p_stop = 0;
    end else begin
      e_run  = btn_run  && !p_run;
      e_step = btn_step && !p_step;
      e_stop = btn_stop && !p_stop;
      p_run = btn_run; p_step = btn_step; p_stop = btn_stop;
      m_period = 64'd1 << rate_sel;
      m_hit = BRK && m_mode == 1 && m_en && brk_en && addr == brk_addr;
      m_was = m_en;
      m_en = 0;
      m_tick = 0;
      m_cnt = m_cnt + (m_was ? 32'd1 : 32'd0);
      if (m_mode == 0) begin
        if (e_stop) m_mode = 0;
        else if (e_step) begin
          m_mode = 2; m_en = 1; m_brk = 0;
        end else if (e_run) begin
          m_mode = 1; m_brk = 0; m_since = 0; m_tick = 1;
        end
      end else if (m_mode == 1) begin
        if (e_stop || m_hit) begin
          m_mode = 0;
          if (m_hit) m_brk = 1;
        end else m_tick = 1;
      end else m_mode = 0;
      if (m_tick) begin
        m_since++;
        if (m_since >= m_period) begin
          m_en = 1; m_since = 0;
        end
      end
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on && !reset) begin
      chk("cpu_en", {31'b0, cpu_en}, {31'b0, m_en});
      chk("running", {31'b0, running}, {31'b0, m_mode == 1});
      chk("state", {30'b0, state}, m_mode);
      chk("brk_hit", {31'b0, brk_hit}, {31'b0, m_brk});
      chk("en_cnt", en_cnt, m_cnt);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn_run = 0; btn_step = 0; btn_stop = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int n, pe;

  initial begin
    #1 reset = 1'b1;
    #20;
    @(negedge clk);
    chk("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
    chk("rst_state", {30'b0, state}, 32'd0);
    chk("rst_cnt", en_cnt, 32'd0);
    reset = 1'b0;
    cmp_on = 1;

    // Single step at cycle 10.
    repeat (10) @(negedge clk);
    btn_step = 1;
    @(negedge clk);
    chk("step_en", {31'b0, cpu_en}, 32'd1);
    chk("step_state", {30'b0, state}, 32'd2);
    btn_step = 0;
    @(negedge clk);
    chk("step_off", {31'b0, cpu_en}, 32'd0);
    chk("step_back", {30'b0, state}, 32'd0);
    chk("step_cnt", en_cnt, 32'd1);

    // Rate 3 run, stop at cycle 20.
    do_reset();
    rate_sel = 4'd3;
    btn_run = 1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      chk("rate3_en", {31'b0, cpu_en}, {31'b0, c == 8 || c == 16});
      if (c == 1) btn_run = 0;
      if (c == 20) btn_stop = 1;
      if (c == 21) btn_stop = 0;
    end
    chk("rate3_cnt", en_cnt, 32'd2);
    chk("rate3_state", {30'b0, state}, 32'd0);

    // Simultaneous edges.
    btn_run = 1; btn_step = 1; btn_stop = 1;
    @(negedge clk);
    chk("all3_state", {30'b0, state}, 32'd0);
    chk("all3_en", {31'b0, cpu_en}, 32'd0);
    btn_run = 0; btn_step = 0; btn_stop = 0;
    @(negedge clk);
    btn_run = 1; btn_step = 1;
    @(negedge clk);
    chk("rs_state", {30'b0, state}, 32'd2);
    chk("rs_en", {31'b0, cpu_en}, 32'd1);
    btn_run = 0; btn_step = 0;
    @(negedge clk);

    // Rate 10 -> 0 with the divider at 500.
    do_reset();
    rate_sel = 4'd10;
    btn_run = 1;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      btn_run = 0;
    end
    chk("r10_quiet", {31'b0, cpu_en}, 32'd0);
    rate_sel = 4'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("r0_cont", {31'b0, cpu_en}, 32'd1);
    end

    // Reset during continuous run.
    #2 reset = 1'b1;
    #1 chk("rst_async", {31'b0, cpu_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cnt2", en_cnt, 32'd0);
    chk("rst_state2", {30'b0, state}, 32'd0);

`ifdef CPU_RUN_BRK_EN
    do_reset();
    rate_sel = 4'd0; brk_en = 1;
    brk_addr = 32'h40; addr = 32'h3E;
    btn_run = 1;
    n = 0; pe = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      btn_run = 0;
      if (pe != 0) addr = addr + 1;
      pe = int'(cpu_en);
      if (cpu_en) n++;
    end
    chk("brk_n", n, 32'd3);
    chk("brk_state", {30'b0, state}, 32'd0);
    chk("brk_hit", {31'b0, brk_hit}, 32'd1);
    btn_step = 1;
    @(negedge clk);
    btn_step = 0;
    chk("brk_clr", {31'b0, brk_hit}, 32'd0);
    chk("brk_step", {30'b0, state}, 32'd2);
    brk_en = 0;
`endif

    // Randomized traffic against the model.
    brk_addr = 32'd2;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      btn_run  = ($urandom % 6) == 0;
      btn_step = ($urandom % 10) == 0;
      btn_stop = ($urandom % 16) == 0;
      if (($urandom % 64) == 0) rate_sel = 4'($urandom % 6);
      brk_en = 1'($urandom % 2);
      addr = $urandom % 4;
      if (($urandom % 700) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
